// File: rtl/strait_pkg.sv
// Shared definitions for the STRAIT fault-tolerant systolic array:
// default array size and the fault-map loader state encoding.
package strait_pkg;

   localparam int SYSTOLIC_SIZE_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_COMMIT = 2'd3
   } loader_state_e;

endpackage

// File: rtl/envm_txn_timer.sv
// Per-transaction wait counter; saturates at TIMEOUT_CYCLES and flags expiry.
module envm_txn_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] count_q;

   assign expired_o = (count_q == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (run_i && !expired_o) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/envm_fault_map_loader.sv
// Moves the faulty-PE map between eNVM and the PE fault storage, one row per
// eNVM transaction, with a per-row ack timeout and a single commit strobe.
module envm_fault_map_loader
   import strait_pkg::*;
#(
   parameter int SYSTOLIC_SIZE  = SYSTOLIC_SIZE_DEF,
   parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 load_start,
   input  logic                                 store_start,
   input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] test_patterns_flat,
   output logic                                 envm_req,
   output logic                                 envm_we,
   output logic [ADDR_WIDTH-1:0]                envm_addr,
   output logic [SYSTOLIC_SIZE-1:0]             envm_wdata,
   input  logic                                 envm_ack,
   input  logic [SYSTOLIC_SIZE-1:0]             envm_rdata,
   output logic                                 wr_en,
   output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] faulty_patterns_flat,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

   loader_state_e          state_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [SYSTOLIC_SIZE-1:0] buf_q [SYSTOLIC_SIZE];
   logic                   err_q;
   logic                   txn_ack;
   logic                   expired;

   // Outputs decode straight from state flops, so they are zero during reset.
   assign envm_req   = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign envm_we    = (state_q == ST_WRITE);
   assign envm_addr  = addr_q;
   assign envm_wdata = envm_we ? buf_q[addr_q] : '0;
   assign wr_en      = (state_q == ST_COMMIT);
   assign done       = (state_q == ST_COMMIT);
   assign busy       = (state_q != ST_IDLE);
   assign err        = err_q;
   assign txn_ack    = envm_req && envm_ack;

   for (genvar gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_flat
      assign faulty_patterns_flat[gi*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] = buf_q[gi];
   end

   envm_txn_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (!envm_req || txn_ack),
      .run_i    (envm_req),
      .expired_o(expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (store_start) begin
                  state_q <= ST_WRITE;
                  addr_q  <= '0;
                  err_q   <= 1'b0;
                  for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                     buf_q[i] <= test_patterns_flat[i*SYSTOLIC_SIZE +: SYSTOLIC_SIZE];
                  end
               end else if (load_start) begin
                  state_q <= ST_READ;
                  addr_q  <= '0;
                  err_q   <= 1'b0;
               end
            end
            ST_READ, ST_WRITE: begin
               // An ack on the expiry cycle still completes the row.
               if (txn_ack) begin
                  if (state_q == ST_READ) begin
                     buf_q[addr_q] <= envm_rdata;
                  end
                  if (addr_q == LAST_ROW) begin
                     state_q <= ST_COMMIT;
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end else if (expired) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
               end
            end
            ST_COMMIT: begin
               state_q <= ST_IDLE;
               addr_q  <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_envm_fault_map_loader.sv
// Randomised bench for envm_fault_map_loader: an eNVM responder with
// programmable ack delay plus a row-array model of the expected fault map.
module tb_envm_fault_map_loader;

   localparam int S  = 8;
   localparam int AW = 3;
   localparam int TO = 255;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           load_start, store_start;
   logic [S*S-1:0] test_patterns_flat;
   logic           envm_req, envm_we;
   logic [AW-1:0]  envm_addr;
   logic [S-1:0]   envm_wdata;
   logic           envm_ack;
   logic [S-1:0]   envm_rdata;
   logic           wr_en;
   logic [S*S-1:0] faulty_patterns_flat;
   logic           busy, done, err;

   int total = 0;
   int bad   = 0;

   // eNVM contents and expected storage rows
   logic [S-1:0] mem      [S];
   logic [S-1:0] exp_rows [S];

   int ack_delay = 0;
   int hold_row  = -1;
   bit idle_ack  = 0;
   int wait_cnt  = 0;
   int stab_err  = 0;
   int wr_addrs[$];
   bit prev_wait = 0;
   logic [AW-1:0] prev_addr;
   logic [S-1:0]  prev_wdata;

   always #5 clk = ~clk;

   envm_fault_map_loader #(
      .SYSTOLIC_SIZE(S),
      .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .load_start(load_start),
      .store_start(store_start),
      .test_patterns_flat(test_patterns_flat),
      .envm_req(envm_req),
      .envm_we(envm_we),
      .envm_addr(envm_addr),
      .envm_wdata(envm_wdata),
      .envm_ack(envm_ack),
      .envm_rdata(envm_rdata),
      .wr_en(wr_en),
      .faulty_patterns_flat(faulty_patterns_flat),
      .busy(busy),
      .done(done),
      .err(err)
   );

   // eNVM responder: acks after ack_delay wait cycles, never on hold_row.
   always @(negedge clk) begin
      if (envm_req === 1'b1) begin
         if (prev_wait && (envm_addr !== prev_addr || envm_wdata !== prev_wdata))
            stab_err++;
         wait_cnt++;
         if (wait_cnt > ack_delay && int'(envm_addr) != hold_row) begin
            envm_ack   = 1'b1;
            envm_rdata = envm_we ? S'($urandom) : mem[envm_addr];
            if (envm_we) begin
               mem[envm_addr] = envm_wdata;
               wr_addrs.push_back(int'(envm_addr));
            end
            wait_cnt  = 0;
            prev_wait = 0;
         end else begin
            envm_ack   = 1'b0;
            envm_rdata = S'($urandom);
            prev_wait  = 1;
            prev_addr  = envm_addr;
            prev_wdata = envm_wdata;
         end
      end else begin
         wait_cnt   = 0;
         prev_wait  = 0;
         envm_ack   = idle_ack;
         envm_rdata = idle_ack ? S'($urandom) : '0;
      end
   end

   function automatic logic [S*S-1:0] flat(input logic [S-1:0] r [S]);
      logic [S*S-1:0] v;
      for (int k = 0; k < S; k++) v[k*S +: S] = r[k];
      return v;
   endfunction

   task automatic rand_mem();
      for (int k = 0; k < S; k++) mem[k] = S'($urandom);
   endtask

   task automatic rand_patterns(output logic [S-1:0] rows [S]);
      for (int k = 0; k < S; k++) rows[k] = S'($urandom);
      test_patterns_flat = flat(rows);
   endtask

   // Issue a start and follow the transfer until busy drops (bounded).
   task automatic run_txn(input bit do_store, input bit do_load,
                          output int wr_cnt, output int cycles,
                          output logic [S*S-1:0] map_at_wr, output logic err_first);
      @(negedge clk);
      store_start = do_store;
      load_start  = do_load;
      @(posedge clk); #1;
      store_start = 1'b0;
      load_start  = 1'b0;
      err_first = err;
      wr_cnt = 0;
      cycles = 0;
      map_at_wr = 'x;
      while (busy === 1'b1 && cycles < 2000) begin
         if (wr_en === 1'b1) begin
            wr_cnt++;
            map_at_wr = faulty_patterns_flat;
         end
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_start = 1'b0;
      store_start = 1'b0;
      test_patterns_flat = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({envm_req, envm_we, envm_addr, envm_wdata, wr_en, busy, done, err} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl: got req=%b we=%b addr=%0d wdata=%h wr_en=%b busy=%b done=%b err=%b, want all 0",
                  envm_req, envm_we, envm_addr, envm_wdata, wr_en, busy, done, err);
      end
      total++;
      if (faulty_patterns_flat !== '0) begin
         bad++;
         $display("FAIL reset_map: got %h want 0", faulty_patterns_flat);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < S; k++) exp_rows[k] = '0;
      $display("txn reset: released");
   endtask

   task automatic test_load_latency();
      int req_ok = 0;
      for (int k = 0; k < S; k++) mem[k] = S'(1) << k;
      ack_delay = 0;
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      for (int c = 1; c <= S; c++) begin
         if (envm_req === 1'b1 && envm_we === 1'b0 && int'(envm_addr) == c - 1 && wr_en === 1'b0)
            req_ok++;
         @(posedge clk); #1;
      end
      total++;
      if (req_ok != S) begin
         bad++;
         $display("FAIL load_req_window: got %0d good read cycles want %0d", req_ok, S);
      end
      total++;
      if ({wr_en, done, err, envm_req} !== 4'b1100) begin
         bad++;
         $display("FAIL load_commit_cycle: got wr_en=%b done=%b err=%b req=%b want 1 1 0 0",
                  wr_en, done, err, envm_req);
      end
      for (int k = 0; k < S; k++) exp_rows[k] = mem[k];
      total++;
      if (faulty_patterns_flat !== flat(exp_rows)) begin
         bad++;
         $display("FAIL load_identity_map: got %h want %h", faulty_patterns_flat, flat(exp_rows));
      end
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
         bad++;
         $display("FAIL load_idle_after: got busy=%b wr_en=%b want 0 0", busy, wr_en);
      end
      $display("txn load identity: map=%h", faulty_patterns_flat);
   endtask

   task automatic test_store_waits();
      logic [S-1:0] rows [S];
      int wr_cnt, cycles;
      logic [S*S-1:0] m;
      logic ef;
      bit order_ok = 1;
      for (int k = 0; k < S; k++) rows[k] = '0;
      rows[3] = 8'hA5;
      test_patterns_flat = flat(rows);
      for (int k = 0; k < S; k++) mem[k] = 8'hFF;
      ack_delay = 2;
      stab_err = 0;
      wr_addrs.delete();
      run_txn(1'b1, 1'b0, wr_cnt, cycles, m, ef);
      total++;
      if (wr_cnt != 1 || m !== flat(rows)) begin
         bad++;
         $display("FAIL store_commit: got wr_cnt=%0d map=%h want 1 map=%h", wr_cnt, m, flat(rows));
      end
      if (wr_addrs.size() != S) order_ok = 0;
      else for (int k = 0; k < S; k++) if (wr_addrs[k] != k) order_ok = 0;
      total++;
      if (!order_ok) begin
         bad++;
         $display("FAIL store_addr_order: got %0d writes, want addrs 0..%0d in order", wr_addrs.size(), S - 1);
      end
      total++;
      if (flat(mem) !== flat(rows)) begin
         bad++;
         $display("FAIL store_wdata: got envm %h want %h", flat(mem), flat(rows));
      end
      total++;
      if (stab_err != 0) begin
         bad++;
         $display("FAIL store_addr_stable: got %0d changes while waiting want 0", stab_err);
      end
      total++;
      if (cycles != S * 3 + 1) begin
         bad++;
         $display("FAIL store_latency: got %0d busy cycles want %0d", cycles, S * 3 + 1);
      end
      for (int k = 0; k < S; k++) exp_rows[k] = rows[k];
      $display("txn store waits=2: writes=%0d cycles=%0d", wr_addrs.size(), cycles);
   endtask

   task automatic test_simultaneous();
      logic [S-1:0] rows [S];
      int wr_cnt = 0;
      int cyc = 0;
      int idle_busy = 0;
      rand_patterns(rows);
      rand_mem();
      ack_delay = 1;
      @(negedge clk);
      load_start = 1'b1;
      store_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      store_start = 1'b0;
      total++;
      if (envm_req !== 1'b1 || envm_we !== 1'b1) begin
         bad++;
         $display("FAIL simul_takes_store: got req=%b we=%b want 1 1", envm_req, envm_we);
      end
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      while (busy === 1'b1 && cyc < 200) begin
         if (wr_en === 1'b1) wr_cnt++;
         @(posedge clk); #1;
         cyc++;
      end
      for (int k = 0; k < S; k++) exp_rows[k] = rows[k];
      total++;
      if (wr_cnt != 1 || faulty_patterns_flat !== flat(exp_rows) || flat(mem) !== flat(rows)) begin
         bad++;
         $display("FAIL simul_result: got wr_cnt=%0d map=%h envm=%h want 1 %h", wr_cnt,
                  faulty_patterns_flat, flat(mem), flat(exp_rows));
      end
      repeat (5) begin
         @(posedge clk); #1;
         if (busy !== 1'b0) idle_busy++;
      end
      total++;
      if (idle_busy != 0) begin
         bad++;
         $display("FAIL busy_load_ignored: got %0d busy cycles after store want 0", idle_busy);
      end
      $display("txn simultaneous start: store taken, map=%h", faulty_patterns_flat);
   endtask

   task automatic test_timeout();
      int cyc = 0;
      int wr_cnt = 0;
      int row5_cycles = 0;
      int wc, cycles;
      logic [S*S-1:0] m;
      logic ef;
      rand_mem();
      ack_delay = 0;
      hold_row = 5;
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      while (err !== 1'b1 && cyc < 600) begin
         if (wr_en === 1'b1) wr_cnt++;
         if (envm_req === 1'b1 && envm_addr == 3'd5) row5_cycles++;
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (err !== 1'b1 || envm_req !== 1'b0 || busy !== 1'b0 || wr_cnt != 0 || done !== 1'b0) begin
         bad++;
         $display("FAIL timeout_abort: got err=%b req=%b busy=%b wr_cnt=%0d want 1 0 0 0",
                  err, envm_req, busy, wr_cnt);
      end
      total++;
      if (row5_cycles < TO || row5_cycles > TO + 2) begin
         bad++;
         $display("FAIL timeout_length: got %0d req cycles on row 5 want %0d..%0d", row5_cycles, TO, TO + 2);
      end
      for (int k = 0; k < 5; k++) exp_rows[k] = mem[k];
      total++;
      if (faulty_patterns_flat !== flat(exp_rows)) begin
         bad++;
         $display("FAIL timeout_buffer_kept: got %h want %h", faulty_patterns_flat, flat(exp_rows));
      end
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: got %b want 1", err);
      end
      $display("txn load timeout row5: err=%b row5_cycles=%0d", err, row5_cycles);
      hold_row = -1;
      run_txn(1'b0, 1'b1, wc, cycles, m, ef);
      for (int k = 0; k < S; k++) exp_rows[k] = mem[k];
      total++;
      if (ef !== 1'b0 || wc != 1 || m !== flat(exp_rows) || err !== 1'b0) begin
         bad++;
         $display("FAIL retry_clears_err: got err_at_start=%b wr_cnt=%0d map=%h err=%b want 0 1 %h 0",
                  ef, wc, m, err, flat(exp_rows));
      end
      $display("txn load retry: map=%h", m);
   endtask

   task automatic test_reset_midload();
      int cyc = 0;
      int wr_cnt = 0;
      int busy_cnt = 0;
      rand_mem();
      ack_delay = 0;
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      while (!(envm_req === 1'b1 && envm_addr == 3'd4) && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({envm_req, envm_we, envm_addr, envm_wdata, wr_en, faulty_patterns_flat, busy, done, err} !== '0) begin
         bad++;
         $display("FAIL reset_midload_outputs: got req=%b addr=%0d busy=%b map=%h want all 0",
                  envm_req, envm_addr, busy, faulty_patterns_flat);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (wr_en === 1'b1) wr_cnt++;
         if (busy === 1'b1) busy_cnt++;
      end
      total++;
      if (wr_cnt != 0 || busy_cnt != 0) begin
         bad++;
         $display("FAIL reset_no_commit: got wr_en=%0d busy=%0d after release want 0 0", wr_cnt, busy_cnt);
      end
      for (int k = 0; k < S; k++) exp_rows[k] = '0;
      $display("txn reset at row 4: wr_en_after=%0d", wr_cnt);
   endtask

   task automatic test_idle_ack();
      logic [S-1:0] rows [S];
      int wc, cycles;
      logic [S*S-1:0] m;
      logic ef;
      int moved = 0;
      rand_patterns(rows);
      ack_delay = 0;
      run_txn(1'b1, 1'b0, wc, cycles, m, ef);
      for (int k = 0; k < S; k++) exp_rows[k] = rows[k];
      @(negedge clk);
      idle_ack = 1;
      repeat (10) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || envm_req !== 1'b0 || wr_en !== 1'b0) moved++;
      end
      idle_ack = 0;
      total++;
      if (moved != 0 || faulty_patterns_flat !== flat(exp_rows)) begin
         bad++;
         $display("FAIL idle_ack_ignored: got %0d active cycles map=%h want 0 map=%h",
                  moved, faulty_patterns_flat, flat(exp_rows));
      end
      $display("txn idle ack x10: map=%h", faulty_patterns_flat);
   endtask

   task automatic test_back_to_back();
      logic [S-1:0] rows [S];
      int wc, cycles;
      logic [S*S-1:0] m;
      logic ef;
      bit is_store;
      for (int n = 0; n < 8; n++) begin
         is_store = 1'($urandom);
         ack_delay = int'($urandom_range(0, 3));
         rand_mem();
         rand_patterns(rows);
         run_txn(is_store, !is_store, wc, cycles, m, ef);
         for (int k = 0; k < S; k++) exp_rows[k] = is_store ? rows[k] : mem[k];
         total++;
         if (wc != 1 || m !== flat(exp_rows) || cycles != S * (ack_delay + 1) + 1) begin
            bad++;
            $display("FAIL b2b_%0d: got wr_cnt=%0d cycles=%0d map=%h want 1 %0d %h", n, wc, cycles,
                     m, S * (ack_delay + 1) + 1, flat(exp_rows));
         end
         if (is_store) begin
            total++;
            if (flat(mem) !== flat(rows)) begin
               bad++;
               $display("FAIL b2b_envm_%0d: got %h want %h", n, flat(mem), flat(rows));
            end
         end
         $display("txn b2b %0d %s delay=%0d cycles=%0d map=%h", n, is_store ? "store" : "load",
                  ack_delay, cycles, m);
      end
   endtask

   initial begin
      envm_ack = 1'b0;
      envm_rdata = '0;
      test_reset();
      test_load_latency();
      test_store_waits();
      test_simultaneous();
      test_timeout();
      test_reset_midload();
      test_idle_ack();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/envm_fault_map_loader.md
ENVM_FAULT_MAP_LOADER -- requirements
Module: envm_fault_map_loader

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8: PE array dimension (S).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE): row address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles an eNVM transaction waits for ack.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load_start  input  1  one-cycle pulse that starts a boot load (eNVM -> storage).
REQ-007 SHALL have port store_start  input  1  one-cycle pulse that starts a store of self-test results (-> eNVM -> storage).
REQ-008 SHALL have port test_patterns_flat  input  S*S  self-test fault map, row k at [k*S +: S]; sampled on an accepted store_start.
REQ-009 SHALL have port envm_req  output  1  eNVM transaction request.
REQ-010 SHALL have port envm_we  output  1  1 = write, 0 = read; valid while envm_req=1.
REQ-011 SHALL have port envm_addr  output  ADDR_WIDTH  eNVM row address.
REQ-012 SHALL have port envm_wdata  output  S  write row data.
REQ-013 SHALL have port envm_ack  input  1  transaction-complete strobe.
REQ-014 SHALL have port envm_rdata  input  S  read row data; valid when envm_ack=1 and envm_we=0.
REQ-015 SHALL have port wr_en  output  1  one-cycle commit strobe to the faulty-PE storage.
REQ-016 SHALL have port faulty_patterns_flat  output  S*S  fault map sent to storage, row k at [k*S +: S].
REQ-017 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse coincident with wr_en.
REQ-019 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement the FSM states IDLE, READ, WRITE, COMMIT; envm_req=1 exactly in READ and WRITE, and envm_we=1 exactly in WRITE.
REQ-021 SHALL leave IDLE as follows: store_start -> WRITE; else load_start -> READ; a simultaneous store_start and load_start SHALL take store.
REQ-022 SHALL ignore start pulses while busy=1.
REQ-023 SHALL clear the row counter and err when a start is accepted, and SHALL copy test_patterns_flat into the row buffer on an accepted store_start.
REQ-024 SHALL hold envm_addr = row counter, and keep envm_addr and envm_wdata stable while envm_req=1.
REQ-025 SHALL complete a transaction on any cycle with envm_req=1 and envm_ack=1; envm_ack with envm_req=0 SHALL be ignored.
REQ-026 SHALL, in READ, write envm_rdata into buffer row [addr] on each ack.
REQ-027 SHALL, in WRITE, drive envm_wdata = buffer row [addr].
REQ-028 SHALL, on an ack with addr = S-1, go to COMMIT; otherwise it SHALL increment addr and stay in the same state; addr SHALL never wrap past S-1.
REQ-029 SHALL, in COMMIT, assert wr_en=1 and done=1 for one cycle, then return to IDLE.
REQ-030 SHALL drive faulty_patterns_flat directly from the row buffer; consumers sample it only on wr_en.
REQ-031 SHALL keep a per-transaction wait counter that is cleared on each ack and on state entry.
REQ-032 SHALL, when the wait counter reaches TIMEOUT_CYCLES without ack: set err=1, drop envm_req in the next cycle, return to IDLE with no wr_en and no done, and keep the buffer contents.
REQ-033 SHALL have a latency, with ack returned in every request cycle, of: start in cycle 0, envm_req in cycles 1..S, wr_en in cycle S+1, busy=0 from cycle S+2.

Reset
REQ-034 SHALL, while rst_n=0 (asynchronously), set state=IDLE and clear the row counter, wait counter and buffer to 0.
REQ-035 SHALL, while rst_n=0, hold envm_req, envm_we, envm_addr, envm_wdata, wr_en, faulty_patterns_flat, busy, done and err at 0.
REQ-036 SHALL, on reset mid-transaction, drop envm_req immediately, and SHALL not emit wr_en after reset release until a new start completes.

Structure
REQ-037 SHALL take the SYSTOLIC_SIZE default and the FSM state encodings from the shared package strait_pkg.
REQ-038 SHALL implement the timeout counter as the sub-module envm_txn_timer (inputs clear/run, output expired).

Verification
REQ-039 SHALL cover a load with immediate acks, rdata row k = 8'h01<<k -> wr_en in cycle 9, faulty_patterns_flat = identity diagonal, done=1, err=0.
REQ-040 SHALL cover a store with test_patterns_flat row3=8'hA5 and all others 0, ack after 2-cycle waits -> eight writes on addr 0..7, wdata[3]=8'hA5, addresses held stable while waiting, then wr_en.
REQ-041 SHALL cover load_start and store_start asserted in the same cycle -> WRITE taken, envm_we=1; a second load_start while busy is ignored.
REQ-042 SHALL cover withholding ack on row 5 of a load for 255 cycles -> err=1, envm_req=0, no wr_en; the next load_start clears err.
REQ-043 SHALL cover rst_n asserted at row 4 of a load -> all outputs 0 at once, and no wr_en after release.
REQ-044 SHALL cover envm_ack pulsed in IDLE -> no state change and no buffer update.
